imm_extend: RTL and testbench

//  RV32I immediate generator for the single-cycle RISC-V datapath. It sits between instruction fetch/decode and the ALU-B / PC-target muxes.
//  - Extracts and sign-extends the I, S, B or J immediate from instr[31:7], selected by immSrc.
//  - Provides a combinational result plus a registered copy for pipelined or debug consumers.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/imm_extend.sv | 46 ++++
 tb/tb_imm_extend.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the single-cycle datapath.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_S = 2'd1,
        IMM_B = 2'd2,
        IMM_J = 2'd3
    } imm_src_e;

endpackage

// File: rtl/imm_extend.sv
// RV32I immediate generator: combinational sign-extended immediate from
// instr[31:7] plus an enable-gated registered copy with async clear.
module imm_extend
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [24:0]     instr,
    input  logic [1:0]      immSrc,
    input  logic            en,
    output logic [XLEN-1:0] immExt,
    output logic [XLEN-1:0] immExt_q
);

    generate
        if (XLEN != 32) begin : g_xlen_check
            $error("imm_extend: only XLEN=32 is supported");
        end
    endgenerate

    // instr is bits [31:7] of the word, so word bit k lives at instr[k-7].
    logic sgn;
    assign sgn = instr[24];

    always_comb begin
        immExt = '0;
        case (imm_src_e'(immSrc))
            IMM_I:   immExt = {{20{sgn}}, instr[24:13]};
            IMM_S:   immExt = {{20{sgn}}, instr[24:18], instr[4:0]};
            IMM_B:   immExt = {{19{sgn}}, sgn, instr[0], instr[23:18], instr[4:1], 1'b0};
            IMM_J:   immExt = {{11{sgn}}, sgn, instr[12:5], instr[13], instr[23:14], 1'b0};
            default: immExt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            immExt_q <= '0;
        end else if (en) begin
            immExt_q <= immExt;
        end
    end

endmodule

// File: tb/tb_imm_extend.sv
// Self-checking bench for imm_extend: directed vectors, random words against
// an arithmetic reference model, and register/reset sequences.
module tb_imm_extend;

    logic        clk;
    logic        rst_n;
    logic [24:0] instr;
    logic [1:0]  immSrc;
    logic        en;
    logic [31:0] immExt;
    logic [31:0] immExt_q;

    int checks   = 0;
    int failures = 0;

    imm_extend #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .instr    (instr),
        .immSrc   (immSrc),
        .en       (en),
        .immExt   (immExt),
        .immExt_q (immExt_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [1:0]  src;
        logic [31:0] exp;
        string       name;
    } vec_t;

    // Reference: gather the scattered immediate bits into an integer, then
    // sign-extend it from its field width with plain arithmetic.
    function automatic logic [31:0] ref_imm(input logic [31:0] w, input int src);
        longint lw;
        longint v;
        int     width;
        lw = longint'(w);
        case (src)
            0: begin
                v = (lw >> 20) & 4095;
                width = 12;
            end
            1: begin
                v = (((lw >> 25) & 127) << 5) | ((lw >> 7) & 31);
                width = 12;
            end
            2: begin
                v = (((lw >> 31) & 1) << 12) | (((lw >> 7) & 1) << 11)
                  | (((lw >> 25) & 63) << 5) | (((lw >> 8) & 15) << 1);
                width = 13;
            end
            default: begin
                v = (((lw >> 31) & 1) << 20) | (((lw >> 12) & 255) << 12)
                  | (((lw >> 20) & 1) << 11) | (((lw >> 21) & 1023) << 1);
                width = 21;
            end
        endcase
        if (v >= (longint'(1) << (width - 1)))
            v = v - (longint'(1) << width);
        return v[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] w;
        logic [31:0] held_imm;

        vecs.push_back('{32'h00500093, 2'd0, 32'h00000005, "I_addi_5"});
        vecs.push_back('{32'hFFF00093, 2'd0, 32'hFFFFFFFF, "I_neg1"});
        vecs.push_back('{32'h00512423, 2'd1, 32'h00000008, "S_sw_8"});
        vecs.push_back('{32'hFE000FA3, 2'd1, 32'hFFFFFFFF, "S_neg1"});
        vecs.push_back('{32'hFE000EE3, 2'd2, 32'hFFFFFFFC, "B_beq_m4"});
        vecs.push_back('{32'h80000063, 2'd2, 32'hFFFFF000, "B_min"});
        vecs.push_back('{32'h001000EF, 2'd3, 32'h00000800, "J_jal_2048"});
        vecs.push_back('{32'h800000EF, 2'd3, 32'hFFF00000, "J_min"});

        rst_n  = 1'b0;
        en     = 1'b0;
        instr  = '0;
        immSrc = 2'd0;
        #2;
        check("reset_q", immExt_q, 32'h0);

        // Directed table (combinational, no clock edge needed).
        foreach (vecs[i]) begin
            w      = vecs[i].word;
            instr  = w[31:7];
            immSrc = vecs[i].src;
            #1;
            check(vecs[i].name, immExt, vecs[i].exp);
        end

        // Random words for every format.
        for (int s = 0; s < 4; s++) begin
            for (int n = 0; n < 200; n++) begin
                w      = $urandom;
                instr  = w[31:7];
                immSrc = 2'(s);
                #1;
                check($sformatf("rand_src%0d", s), immExt, ref_imm(w, s));
            end
        end
        check("q_held_in_reset", immExt_q, 32'h0);

        // Release reset and capture the I-case value.
        @(negedge clk);
        rst_n  = 1'b1;
        w      = 32'h00500093;
        instr  = w[31:7];
        immSrc = 2'd0;
        en     = 1'b1;
        @(posedge clk);
        #1;
        check("capture_I", immExt_q, 32'h00000005);

        // en=0: new instruction must not be captured.
        @(negedge clk);
        en     = 1'b0;
        w      = 32'hFFF00093;
        instr  = w[31:7];
        @(posedge clk);
        #1;
        check("hold_en0", immExt_q, 32'h00000005);
        check("comb_tracks_en0", immExt, 32'hFFFFFFFF);

        // Capture again with en=1.
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        check("capture_neg1", immExt_q, 32'hFFFFFFFF);

        // Async reset between edges clears only the register.
        @(negedge clk);
        held_imm = immExt;
        rst_n = 1'b0;
        #1;
        check("async_clear_q", immExt_q, 32'h0);
        check("async_clear_comb", immExt, held_imm);

        // Held at zero across an edge while reset is low, comb still tracks.
        w      = 32'h001000EF;
        instr  = w[31:7];
        immSrc = 2'd3;
        @(posedge clk);
        #1;
        check("reset_hold_q", immExt_q, 32'h0);
        check("reset_comb_J", immExt, 32'h00000800);

        // First posedge after release with en=1 captures.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_no_edge", immExt_q, 32'h0);
        @(posedge clk);
        #1;
        check("first_capture_J", immExt_q, 32'h00000800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
